sd_cmd_phy: RTL and testbench

- Serial CMD-line engine for the SD host. It takes the 40-bit command frame from the command control layer (physiccmds) on a strobe/ack handshake.
- It appends CRC7 and the end bit, then shifts the 48-bit frame onto the CMD pin.
- It then releases the line and captures the card response (none, 48-bit or 136-bit), checks it, and returns it on a strobe/ack handshake.
- Clock is the SD card clock; one CMD bit per Clock cycle.

---
 rtl/sd_cmd_pkg.sv | 31 +++
 rtl/sd_cmd_phy_crc7.sv | 37 +++
 rtl/sd_cmd_phy.sv | 199 +++++++++++++++++++
 tb/tb_sd_cmd_phy.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD-line engine: FSM states, response types,
// CRC7 polynomial and frame lengths.
package sd_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_TURN,
      ST_WAIT_START,
      ST_RECEIVE,
      ST_NCC,
      ST_CHECK,
      ST_DONE
   } state_e;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_48   = 2'd1;
   localparam logic [1:0] RESP_136  = 2'd2;

   // x^7 + x^3 + 1 with the x^7 term implied by the shift
   localparam logic [6:0] CRC7_POLY = 7'h09;

   localparam int CMD_LEN       = 40;
   localparam int FRAME_LEN_48  = 48;
   localparam int FRAME_LEN_136 = 136;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/sd_cmd_phy_crc7.sv
// Serial CRC7 generator shared by the transmit and receive paths.
// Clear has priority over enable; both act on the rising edge.
module sd_crc7
   import sd_cmd_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       clear_i,
   input  logic       enable_i,
   input  logic       bit_i,
   output logic [6:0] crc_o
);

   logic [6:0] crc_q, crc_d;
   logic       feedback;

   always_comb begin
      feedback = crc_q[6] ^ bit_i;
      crc_d    = crc_q;
      if (clear_i) begin
         crc_d = '0;
      end else if (enable_i) begin
         crc_d = {crc_q[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_phy.sv
// SD CMD-line engine: shifts out a 48-bit command frame with CRC7, then
// captures and checks the card response (none, 48-bit or 136-bit).
module sd_cmd_phy
   import sd_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned NCC_CYCLES     = 8,
   parameter int unsigned TURN_CYCLES    = 2
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         iStrobe,
   input  logic [39:0]  iCmd,
   input  logic [1:0]   iResp_type,
   input  logic         iIdle,
   input  logic         iAck,
   output logic         oSerial_ready,
   output logic         oAck,
   output logic         oStrobe,
   output logic [135:0] oResp,
   output logic         oTimeout,
   output logic         oCrc_error,
   output logic         oCmd_pin,
   output logic         oCmd_oe,
   input  logic         iCmd_pin
);

   localparam logic [7:0] TX_CRC_START = 8'(CMD_LEN);
   localparam logic [7:0] TX_LAST      = 8'(FRAME_LEN_48 - 1);
   localparam logic [7:0] RX_LAST_136  = 8'(FRAME_LEN_136 - 1);
   localparam logic [7:0] TURN_LAST    = 8'(TURN_CYCLES - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] NCC_LAST     = 8'(NCC_CYCLES - 1);
   // R2 start, transmit and reserved bits are not covered by its CRC
   localparam logic [7:0] R2_CRC_FIRST = 8'd8;

   state_e state_q, state_d;

   logic [7:0]   cnt_q, cnt_d;
   logic [39:0]  tx_q, tx_d;
   logic         is_none_q, is_none_d;
   logic         is_136_q, is_136_d;
   logic [135:0] resp_q, resp_d;
   logic         ack_q, ack_d;
   logic         timeout_q, timeout_d;
   logic         crc_err_q, crc_err_d;

   logic         accept, abort, start_bit;
   logic [7:0]   rx_last, rx_crc_first, rx_crc_last;
   logic         crc_clear, crc_en, crc_bit;
   logic [6:0]   crc;
   logic [2:0]   crc_sel;

   assign accept    = (state_q == ST_IDLE) && iStrobe && !iIdle;
   assign abort     = (state_q != ST_IDLE) && iIdle;
   assign start_bit = (state_q == ST_WAIT_START) && !iCmd_pin;

   assign rx_last      = is_136_q ? RX_LAST_136 : TX_LAST;
   assign rx_crc_first = is_136_q ? R2_CRC_FIRST : 8'd1;
   assign rx_crc_last  = rx_last - 8'd8;

   // A zero start bit leaves a cleared CRC at zero, so clearing on it is exact
   assign crc_clear = accept || start_bit;
   assign crc_en    = ((state_q == ST_SEND) && (cnt_q < TX_CRC_START)) ||
                      ((state_q == ST_RECEIVE) && (cnt_q >= rx_crc_first) &&
                       (cnt_q <= rx_crc_last));
   assign crc_bit   = (state_q == ST_SEND) ? tx_q[CMD_LEN-1] : iCmd_pin;
   assign crc_sel   = 3'(TX_LAST - 8'd1 - cnt_q);

   sd_crc7 u_crc7 (
      .Clock    (Clock),
      .Reset    (Reset),
      .clear_i  (crc_clear),
      .enable_i (crc_en),
      .bit_i    (crc_bit),
      .crc_o    (crc)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:       if (accept) state_d = ST_SEND;
         ST_SEND:       if (cnt_q == TX_LAST) state_d = is_none_q ? ST_NCC : ST_TURN;
         ST_TURN:       if (cnt_q >= TURN_LAST) state_d = ST_WAIT_START;
         ST_WAIT_START: begin
            if (!iCmd_pin) begin
               state_d = ST_RECEIVE;
            end else if (cnt_q >= TIMEOUT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_RECEIVE:    if (cnt_q == rx_last) state_d = ST_CHECK;
         ST_NCC:        if (cnt_q >= NCC_LAST) state_d = ST_DONE;
         ST_CHECK:      state_d = ST_DONE;
         ST_DONE:       if (iAck) state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   always_comb begin
      oSerial_ready = (state_q == ST_IDLE);
      oCmd_oe       = (state_q == ST_SEND);
      oStrobe       = (state_q == ST_DONE);
      oCmd_pin      = 1'b1;
      if (state_q == ST_SEND) begin
         if (cnt_q < TX_CRC_START) begin
            oCmd_pin = tx_q[CMD_LEN-1];
         end else if (cnt_q < TX_LAST) begin
            oCmd_pin = crc[crc_sel];
         end
      end
   end

   // NOTE: every _d gets a default before the case so no path infers a latch.
   always_comb begin
      cnt_d     = '0;
      tx_d      = tx_q;
      is_none_d = is_none_q;
      is_136_d  = is_136_q;
      resp_d    = resp_q;
      timeout_d = timeout_q;
      crc_err_d = crc_err_q;
      ack_d     = accept;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               tx_d      = iCmd;
               is_none_d = (iResp_type == RESP_NONE);
               is_136_d  = (iResp_type == RESP_136);
               resp_d    = '0;
               timeout_d = 1'b0;
               crc_err_d = 1'b0;
            end
         end
         ST_SEND: begin
            tx_d = {tx_q[CMD_LEN-2:0], 1'b0};
            if (cnt_q != TX_LAST) cnt_d = cnt_q + 8'd1;
         end
         ST_TURN, ST_NCC: cnt_d = sat_inc(cnt_q);
         ST_WAIT_START: begin
            if (!iCmd_pin) begin
               cnt_d  = 8'd1;
               resp_d = {resp_q[FRAME_LEN_136-2:0], iCmd_pin};
            end else begin
               cnt_d = sat_inc(cnt_q);
               if (cnt_q >= TIMEOUT_LAST) timeout_d = 1'b1;
            end
         end
         ST_RECEIVE: begin
            cnt_d  = sat_inc(cnt_q);
            resp_d = {resp_q[FRAME_LEN_136-2:0], iCmd_pin};
         end
         ST_CHECK: crc_err_d = (crc != resp_q[7:1]) || !resp_q[0];
         default: ;
      endcase
      if (abort) begin
         timeout_d = 1'b0;
         crc_err_d = 1'b0;
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt_q     <= '0;
         tx_q      <= '0;
         is_none_q <= 1'b0;
         is_136_q  <= 1'b0;
         resp_q    <= '0;
         ack_q     <= 1'b0;
         timeout_q <= 1'b0;
         crc_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         tx_q      <= tx_d;
         is_none_q <= is_none_d;
         is_136_q  <= is_136_d;
         resp_q    <= resp_d;
         ack_q     <= ack_d;
         timeout_q <= timeout_d;
         crc_err_q <= crc_err_d;
      end
   end

   assign oAck       = ack_q;
   assign oResp      = resp_q;
   assign oTimeout   = timeout_q;
   assign oCrc_error = crc_err_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Scoreboard bench for sd_cmd_phy: a driver issues commands, a card model
// answers on the CMD pin, and a monitor checks TX frames and responses.
module tb_sd_cmd_phy;

   localparam int TIMEOUT_CYCLES = 64;
   localparam int NCC_CYCLES     = 8;
   localparam int TURN_CYCLES    = 2;

   logic         Clock = 1'b0;
   logic         Reset = 1'b1;
   logic         iStrobe = 1'b0;
   logic [39:0]  iCmd = '0;
   logic [1:0]   iResp_type = '0;
   logic         iIdle = 1'b0;
   logic         iAck = 1'b0;
   logic         iCmd_pin = 1'b1;
   logic         oSerial_ready, oAck, oStrobe, oTimeout, oCrc_error;
   logic         oCmd_pin, oCmd_oe;
   logic [135:0] oResp;

   always #5 Clock = ~Clock;

   sd_cmd_phy #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .NCC_CYCLES     (NCC_CYCLES),
      .TURN_CYCLES    (TURN_CYCLES)
   ) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .iStrobe       (iStrobe),
      .iCmd          (iCmd),
      .iResp_type    (iResp_type),
      .iIdle         (iIdle),
      .iAck          (iAck),
      .oSerial_ready (oSerial_ready),
      .oAck          (oAck),
      .oStrobe       (oStrobe),
      .oResp         (oResp),
      .oTimeout      (oTimeout),
      .oCrc_error    (oCrc_error),
      .oCmd_pin      (oCmd_pin),
      .oCmd_oe       (oCmd_oe),
      .iCmd_pin      (iCmd_pin)
   );

   typedef struct {
      logic [135:0] resp;
      logic         timeout;
      logic         crc_err;
      int           latency;
   } exp_t;

   typedef struct {
      int          nbits;
      logic [47:0] bits;
   } tx_exp_t;

   typedef struct {
      bit           reply;
      int           delay;
      int           len;
      logic [135:0] frame;
   } job_t;

   exp_t    sb_q[$];
   tx_exp_t tx_q[$];
   job_t    card_q[$];
   int      n_vec = 0;
   int      n_fail = 0;
   bit      card_busy = 1'b0;

   task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // CRC7 as the remainder of data(x) * x^7 divided by x^7+x^3+1
   function automatic logic [6:0] crc7_ref(input logic [135:0] data, input int n);
      logic [142:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i+7] = data[i];
      for (int i = n + 6; i >= 7; i--) begin
         if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
      end
      return v[6:0];
   endfunction

   function automatic logic [47:0] tx_frame(input logic [39:0] cmd);
      return {cmd, crc7_ref(136'(cmd), 40), 1'b1};
   endfunction

   function automatic logic [135:0] make_frame(input int len);
      logic [135:0] f;
      logic [119:0] body;
      f = '0;
      if (len == 48) begin
         body = '0;
         body[39:0] = {2'b00, 6'($urandom), 32'($urandom)};
         f[47:0] = {body[39:0], crc7_ref(136'(body[39:0]), 40), 1'b1};
      end else begin
         body = 120'({$urandom, $urandom, $urandom, $urandom});
         f = {8'h3F, body, crc7_ref(136'(body), 120), 1'b1};
      end
      return f;
   endfunction

   function automatic exp_t model(input logic [1:0] rtype, input job_t j);
      exp_t e;
      e.resp = '0;
      e.timeout = 1'b0;
      e.crc_err = 1'b0;
      e.latency = -1;
      if (rtype == 2'd0) begin
         e.latency = NCC_CYCLES;
      end else if (!j.reply || j.delay < TURN_CYCLES || j.delay > TIMEOUT_CYCLES - 1) begin
         e.timeout = 1'b1;
         e.latency = TIMEOUT_CYCLES;
      end else begin
         e.resp = j.frame;
         if (j.len == 136)
            e.crc_err = (crc7_ref(136'(j.frame[127:8]), 120) != j.frame[7:1]) || !j.frame[0];
         else
            e.crc_err = (crc7_ref(136'(j.frame[47:8]), 40) != j.frame[7:1]) || !j.frame[0];
      end
      return e;
   endfunction

   task automatic wait_ready();
      int w;
      w = 0;
      @(negedge Clock);
      while ((!oSerial_ready || card_busy) && w < 300) begin
         @(negedge Clock);
         w++;
      end
      check("ready", 136'(oSerial_ready), 136'(1));
   endtask

   task automatic run_txn(input logic [39:0] cmd, input logic [47:0] exp_tx, input logic [1:0] rtype,
                          input job_t j, input int ack_delay);
      exp_t    e;
      tx_exp_t t;
      int      waited;
      wait_ready();
      t.nbits = 48;
      t.bits  = exp_tx;
      tx_q.push_back(t);
      e = model(rtype, j);
      sb_q.push_back(e);
      if (rtype == 2'd0) j.reply = 1'b0;
      card_q.push_back(j);
      iCmd = cmd;
      iResp_type = rtype;
      iStrobe = 1'b1;
      @(negedge Clock);
      check("ack_pulse", 136'(oAck), 136'(1));
      iStrobe = 1'b0;
      @(negedge Clock);
      check("ack_single", 136'(oAck), 136'(0));
      waited = 0;
      while (!oStrobe && waited < 400) begin
         @(negedge Clock);
         waited++;
      end
      check("strobe_wait", 136'(oStrobe), 136'(1));
      if (oStrobe) begin
         for (int i = 0; i < ack_delay; i++) begin
            @(negedge Clock);
            check("strobe_hold", 136'(oStrobe), 136'(1));
            check("resp_hold", oResp, e.resp);
         end
         iAck = 1'b1;
         @(negedge Clock);
         iAck = 1'b0;
         check("strobe_drop", 136'(oStrobe), 136'(0));
      end
   endtask

   task automatic run_abort(input logic [39:0] cmd);
      tx_exp_t t;
      job_t    j;
      logic [47:0] f;
      wait_ready();
      f = tx_frame(cmd);
      t.nbits = 21;
      t.bits  = f >> 27;
      tx_q.push_back(t);
      j.reply = 1'b0; j.delay = 0; j.len = 48; j.frame = '0;
      card_q.push_back(j);
      iCmd = cmd;
      iResp_type = 2'd1;
      iStrobe = 1'b1;
      @(negedge Clock);
      check("abort_ack", 136'(oAck), 136'(1));
      iStrobe = 1'b0;
      repeat (9) @(negedge Clock);
      iStrobe = 1'b1;
      @(negedge Clock);
      check("busy_no_ack", 136'(oAck), 136'(0));
      iStrobe = 1'b0;
      repeat (10) @(negedge Clock);
      iIdle = 1'b1;
      @(negedge Clock);
      check("abort_oe", 136'(oCmd_oe), 136'(0));
      check("abort_ready", 136'(oSerial_ready), 136'(1));
      check("abort_flags", 136'({oTimeout, oCrc_error}), 136'(0));
      iIdle = 1'b0;
      repeat (20) begin
         @(negedge Clock);
         check("abort_no_strobe", 136'(oStrobe), 136'(0));
      end
   endtask

   // Card model: answers each CMD release with the next queued job
   initial begin : card
      bit   prev_oe;
      job_t j;
      prev_oe = 1'b0;
      forever begin
         @(negedge Clock);
         if (prev_oe && !oCmd_oe && card_q.size() != 0) begin
            j = card_q.pop_front();
            if (j.reply) begin
               card_busy = 1'b1;
               repeat (j.delay) @(negedge Clock);
               for (int i = j.len - 1; i >= 0; i--) begin
                  iCmd_pin = j.frame[i];
                  @(negedge Clock);
               end
               iCmd_pin = 1'b1;
               card_busy = 1'b0;
            end
         end
         prev_oe = oCmd_oe;
      end
   end

   // Monitor: collects driven CMD bits and scores each response strobe
   initial begin : monitor
      bit          prev_oe, prev_stb;
      int          since_rel, ncap;
      logic [47:0] cap;
      exp_t        e;
      tx_exp_t     t;
      prev_oe = 1'b0; prev_stb = 1'b0; since_rel = 0; ncap = 0; cap = '0;
      forever begin
         @(negedge Clock);
         if (oCmd_oe) begin
            cap = {cap[46:0], oCmd_pin};
            ncap++;
         end
         if (prev_oe && !oCmd_oe) begin
            since_rel = 0;
            if (tx_q.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL tx_unexpected: got frame %h with no command pending", cap);
            end else begin
               t = tx_q.pop_front();
               check("tx_len", 136'(ncap), 136'(t.nbits));
               check("tx_bits", 136'(cap), 136'(t.bits));
            end
            ncap = 0;
            cap = '0;
         end else begin
            since_rel++;
         end
         if (oStrobe && !prev_stb) begin
            if (sb_q.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL strobe_unexpected: got oStrobe with resp %h, none pending", oResp);
            end else begin
               e = sb_q.pop_front();
               check("resp", oResp, e.resp);
               check("timeout", 136'(oTimeout), 136'(e.timeout));
               check("crc_error", 136'(oCrc_error), 136'(e.crc_err));
               if (e.latency >= 0) check("latency", 136'(since_rel), 136'(e.latency));
            end
         end
         prev_oe = oCmd_oe;
         prev_stb = oStrobe;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      job_t        j;
      logic [39:0] cmd;
      logic [1:0]  rtype;
      int          len;

      repeat (3) @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
      check("rst_ready", 136'(oSerial_ready), 136'(1));
      check("rst_oe", 136'(oCmd_oe), 136'(0));
      check("rst_pin", 136'(oCmd_pin), 136'(1));
      check("rst_strobe", 136'(oStrobe), 136'(0));
      check("rst_ack", 136'(oAck), 136'(0));
      check("rst_flags", 136'({oTimeout, oCrc_error}), 136'(0));
      check("rst_resp", oResp, 136'(0));

      // CMD0, no response
      j.reply = 1'b0; j.delay = 0; j.len = 48; j.frame = '0;
      run_txn(40'h40_0000_0000, 48'h40_0000_0000_95, 2'd0, j, 0);

      // CMD8 with a valid R7
      j.reply = 1'b1; j.delay = 5; j.len = 48; j.frame = 136'(48'h08_0000_01AA_13);
      run_txn(40'h48_0000_01AA, 48'h48_0000_01AA_87, 2'd1, j, 2);

      // CMD8 with one response CRC bit flipped
      j.frame = 136'(48'h08_0000_01AA_13 ^ 48'h04);
      run_txn(40'h48_0000_01AA, 48'h48_0000_01AA_87, 2'd1, j, 1);

      // R2 (136-bit) response
      j.reply = 1'b1; j.delay = 3; j.len = 136; j.frame = make_frame(136);
      run_txn(40'h42_0000_0000, tx_frame(40'h42_0000_0000), 2'd2, j, 0);

      // No reply, ack held off
      j.reply = 1'b0; j.delay = 0; j.len = 48; j.frame = '0;
      run_txn(40'h4D_1234_0000, tx_frame(40'h4D_1234_0000), 2'd1, j, 10);

      // Start bit on the last cycle of the window
      j.reply = 1'b1; j.delay = TIMEOUT_CYCLES - 1; j.len = 48; j.frame = make_frame(48);
      run_txn(40'h4D_0001_0000, tx_frame(40'h4D_0001_0000), 2'd1, j, 0);

      run_abort(40'h51_DEAD_BEEF);

      for (int n = 0; n < 30; n++) begin
         cmd   = {2'b01, 6'($urandom), 32'($urandom)};
         rtype = 2'($urandom_range(0, 3));
         len   = (rtype == 2'd2) ? 136 : 48;
         j.len   = len;
         j.reply = ($urandom_range(0, 5) != 0);
         j.delay = $urandom_range(TURN_CYCLES, TIMEOUT_CYCLES - 1);
         j.frame = make_frame(len);
         if ($urandom_range(0, 2) == 0) j.frame[$urandom_range(len - 2, 0)] ^= 1'b1;
         run_txn(cmd, tx_frame(cmd), rtype, j, $urandom_range(0, 4));
      end

      repeat (20) @(negedge Clock);
      check("sb_drain", 136'(sb_q.size()), 136'(0));
      check("tx_drain", 136'(tx_q.size()), 136'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
